// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler driving a 16:1 mux select and one-hot grant with burst hold.
// Optional MUX_SCHED_LOCK_EN adds a `lock` input that pins the current grant past its burst.
module mux16_rr_sched #(
   parameter int N       = 16,
   parameter int SEL_W   = 4,
   parameter int BURST_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [N-1:0]       req,
   input  logic [BURST_W-1:0] burst_len,
`ifdef MUX_SCHED_LOCK_EN
   input  logic               lock,
`endif
   output logic [SEL_W-1:0]   sel,
   output logic [N-1:0]       grant,
   output logic               valid,
   output logic [BURST_W-1:0] busy_cnt
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t             state;
   logic [SEL_W-1:0]   last_sel;
   logic [SEL_W-1:0]   winner;
   logic [SEL_W-1:0]   idx;
   logic               any_req;
   logic               last_cyc;
   logic               end_g;
   logic               start;
   logic [BURST_W-1:0] blen;

   // Walk backwards so the lowest offset from last_sel+1 is the final assignment.
   always_comb begin
      winner = '0;
      idx    = '0;
      for (int k = N; k >= 1; k--) begin
         idx = SEL_W'((int'(last_sel) + k) % N);
         if (req[idx]) winner = idx;
      end
   end

   assign any_req = |req;
   assign blen    = (burst_len == '0) ? BURST_W'(1) : burst_len;

`ifdef MUX_SCHED_LOCK_EN
   assign last_cyc = (busy_cnt == BURST_W'(1)) && !lock;
`else
   assign last_cyc = (busy_cnt == BURST_W'(1));
`endif

   assign end_g = last_cyc || !req[sel] || !en;
   // A new grant loads from IDLE, or back-to-back at the end of a HOLD.
   assign start = en && any_req && ((state == IDLE) || end_g);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sel      <= '0;
         grant    <= '0;
         valid    <= 1'b0;
         busy_cnt <= '0;
         last_sel <= SEL_W'(N - 1);
      end else if (start) begin
         state    <= HOLD;
         sel      <= winner;
         grant    <= {{(N-1){1'b0}}, 1'b1} << winner;
         valid    <= 1'b1;
         last_sel <= winner;
         busy_cnt <= blen;
      end else if (state == HOLD && !end_g) begin
         // Under lock the count parks at 1 instead of wrapping.
         if (busy_cnt > BURST_W'(1)) busy_cnt <= busy_cnt - BURST_W'(1);
      end else begin
         state    <= IDLE;
         grant    <= '0;
         valid    <= 1'b0;
         busy_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Directed vector bench for mux16_rr_sched: table of cycle vectors plus reset/RR/lock sequences.
module tb_mux16_rr_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [15:0] req;
   logic [3:0]  burst_len;
   logic        lock;
   logic [3:0]  sel;
   logic [15:0] grant;
   logic        valid;
   logic [3:0]  busy_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mux16_rr_sched dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .req       (req),
      .burst_len (burst_len),
`ifdef MUX_SCHED_LOCK_EN
      .lock      (lock),
`endif
      .sel       (sel),
      .grant     (grant),
      .valid     (valid),
      .busy_cnt  (busy_cnt)
   );

   typedef struct {
      logic        en;
      logic [15:0] req;
      logic [3:0]  bl;
      logic [3:0]  sel;
      logic [15:0] grant;
      logic        valid;
      logic [3:0]  busy;
   } vec_t;

   localparam int NV = 17;
   vec_t tv [NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] s, input logic [15:0] g,
                          input logic v, input logic [3:0] b);
      chk({tag, ".sel"},      32'(sel),      32'(s));
      chk({tag, ".grant"},    32'(grant),    32'(g));
      chk({tag, ".valid"},    32'(valid),    32'(v));
      chk({tag, ".busy_cnt"}, 32'(busy_cnt), 32'(b));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(logic e, logic [15:0] r, logic [3:0] bl, logic [3:0] s,
                               logic [15:0] g, logic v, logic [3:0] b);
      vec_t x;
      x.en = e; x.req = r; x.bl = bl; x.sel = s; x.grant = g; x.valid = v; x.busy = b;
      return x;
   endfunction

   initial begin
      // single request, back-to-back regrant, burst_len ignored mid-hold
      tv[0]  = mk(1, 16'h0001, 4, 0, 16'h0001, 1, 4);
      tv[1]  = mk(1, 16'h0001, 9, 0, 16'h0001, 1, 3);
      tv[2]  = mk(1, 16'h0001, 9, 0, 16'h0001, 1, 2);
      tv[3]  = mk(1, 16'h0001, 9, 0, 16'h0001, 1, 1);
      tv[4]  = mk(1, 16'h0001, 4, 0, 16'h0001, 1, 4);
      tv[5]  = mk(1, 16'h0000, 4, 0, 16'h0000, 0, 0);
      // early release hands over to requester 5 with no gap
      tv[6]  = mk(1, 16'h0030, 8, 4, 16'h0010, 1, 8);
      tv[7]  = mk(1, 16'h0030, 8, 4, 16'h0010, 1, 7);
      tv[8]  = mk(1, 16'h0020, 8, 5, 16'h0020, 1, 8);
      tv[9]  = mk(1, 16'h0020, 8, 5, 16'h0020, 1, 7);
      tv[10] = mk(1, 16'h0020, 8, 5, 16'h0020, 1, 6);
      tv[11] = mk(1, 16'h0020, 8, 5, 16'h0020, 1, 5);
      // en drop, en blocking, burst_len 0
      tv[12] = mk(0, 16'h0020, 8, 5, 16'h0000, 0, 0);
      tv[13] = mk(0, 16'h0020, 0, 5, 16'h0000, 0, 0);
      tv[14] = mk(1, 16'h0020, 0, 5, 16'h0020, 1, 1);
      tv[15] = mk(1, 16'h0020, 0, 5, 16'h0020, 1, 1);
      tv[16] = mk(1, 16'h0000, 0, 5, 16'h0000, 0, 0);

      rst_n = 1'b0; en = 1'b0; req = '0; burst_len = '0; lock = 1'b0;
      repeat (3) tick();
      chk_out("reset", 4'd0, 16'h0000, 1'b0, 4'd0);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         en = tv[i].en; req = tv[i].req; burst_len = tv[i].bl;
         tick();
         chk_out($sformatf("vec%0d", i), tv[i].sel, tv[i].grant, tv[i].valid, tv[i].busy);
      end

      // round robin over all 16 requesters from a fresh reset
      rst_n = 1'b0; #2; rst_n = 1'b1;
      en = 1'b1; req = 16'hFFFF; burst_len = 4'd1;
      for (int k = 0; k < 17; k++) begin
         logic [3:0]  es;
         logic [15:0] eg;
         es = 4'(k % 16);
         eg = 16'h0001 << es;
         tick();
         chk_out($sformatf("rr%0d", k), es, eg, 1'b1, 4'd1);
      end

      // async reset mid-grant, priority restarts at requester 0
      rst_n = 1'b0; #2; rst_n = 1'b1;
      req = 16'h0200; burst_len = 4'd5;
      tick(); chk_out("ar_g", 4'd9, 16'h0200, 1'b1, 4'd5);
      tick(); tick(); chk_out("ar_b3", 4'd9, 16'h0200, 1'b1, 4'd3);
      #3 rst_n = 1'b0;
      #1 chk_out("ar_async", 4'd0, 16'h0000, 1'b0, 4'd0);
      req = 16'h0202;
      #2 rst_n = 1'b1;
      tick(); chk_out("ar_first", 4'd1, 16'h0002, 1'b1, 4'd5);

`ifdef MUX_SCHED_LOCK_EN
      rst_n = 1'b0; #2; rst_n = 1'b1;
      lock = 1'b1; req = 16'h0003; burst_len = 4'd2;
      tick(); chk_out("lk_g", 4'd0, 16'h0001, 1'b1, 4'd2);
      tick(); chk_out("lk_b1", 4'd0, 16'h0001, 1'b1, 4'd1);
      for (int k = 0; k < 10; k++) begin
         tick(); chk_out($sformatf("lk_hold%0d", k), 4'd0, 16'h0001, 1'b1, 4'd1);
      end
      lock = 1'b0;
      tick(); chk_out("lk_rel", 4'd1, 16'h0002, 1'b1, 4'd2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
